// File: rtl/add8_err_monitor.sv
// Exhaustive 8x8 sweep monitor: drives every operand pair into an approximate
// adder and accumulates error statistics of its output against the exact sum.
module add8_err_monitor #(
    parameter int LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [7:0]  stim_a,
    output logic [7:0]  stim_b,
    input  logic [8:0]  dut_o,
    output logic        busy,
    output logic        done,
    output logic [24:0] err_sum,
    output logic [34:0] err_sq,
    output logic [8:0]  err_max,
    output logic [16:0] err_cnt
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t      state_q, state_d;
    logic [15:0] k_q, k_d;
    logic [1:0]  drain_q, drain_d;
    logic [24:0] sum_q, sum_d;
    logic [34:0] sq_q, sq_d;
    logic [8:0]  max_q, max_d;
    logic [16:0] cnt_q, cnt_d;

    logic [8:0]  exactNow, exactAligned, errAbs;
    logic [17:0] errSquared;
    logic        sampleNow, sampleValid;

    assign exactNow  = {1'b0, stim_a} + {1'b0, stim_b};
    assign sampleNow = (state_q == RUN);

    // Exact sum and its valid flag travel LAT stages so they meet dut_o for the same operands.
    generate
        if (LAT == 0) begin : gNoPipe
            assign exactAligned = exactNow;
            assign sampleValid  = sampleNow;
        end else begin : gPipe
            logic [8:0] sumLine_q [LAT];
            logic       vldLine_q [LAT];

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    for (int i = 0; i < LAT; i++) begin
                        sumLine_q[i] <= '0;
                        vldLine_q[i] <= 1'b0;
                    end
                end else begin
                    sumLine_q[0] <= exactNow;
                    vldLine_q[0] <= sampleNow;
                    for (int i = 1; i < LAT; i++) begin
                        sumLine_q[i] <= sumLine_q[i-1];
                        vldLine_q[i] <= vldLine_q[i-1];
                    end
                end
            end

            assign exactAligned = sumLine_q[LAT-1];
            assign sampleValid  = vldLine_q[LAT-1];
        end
    endgenerate

    assign errAbs     = (dut_o >= exactAligned) ? (dut_o - exactAligned) : (exactAligned - dut_o);
    assign errSquared = errAbs * errAbs;

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        drain_d = drain_q;
        sum_d   = sum_q;
        sq_d    = sq_q;
        max_d   = max_q;
        cnt_d   = cnt_q;
        stim_a  = 8'd0;
        stim_b  = 8'd0;
        busy    = 1'b0;
        done    = 1'b0;

        if (sampleValid) begin
            sum_d = sum_q + {16'd0, errAbs};
            sq_d  = sq_q + {17'd0, errSquared};
            max_d = (errAbs > max_q) ? errAbs : max_q;
            cnt_d = cnt_q + {16'd0, |errAbs};
        end

        case (state_q)
            IDLE, DONE: begin
                done = (state_q == DONE);
                if (start) begin
                    state_d = RUN;
                    k_d     = '0;
                    sum_d   = '0;
                    sq_d    = '0;
                    max_d   = '0;
                    cnt_d   = '0;
                end
            end
            RUN: begin
                busy   = 1'b1;
                stim_a = k_q[7:0];
                stim_b = k_q[15:8];
                k_d    = k_q + 16'd1;
                if (k_q == 16'hFFFF) begin
                    state_d = (LAT > 0) ? DRAIN : DONE;
                    drain_d = '0;
                end
            end
            DRAIN: begin
                busy    = 1'b1;
                drain_d = drain_q + 2'd1;
                if (drain_q == 2'(LAT - 1)) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            k_q     <= '0;
            drain_q <= '0;
            sum_q   <= '0;
            sq_q    <= '0;
            max_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            drain_q <= drain_d;
            sum_q   <= sum_d;
            sq_q    <= sq_d;
            max_q   <= max_d;
            cnt_q   <= cnt_d;
        end
    end

    assign err_sum = sum_q;
    assign err_sq  = sq_q;
    assign err_max = max_q;
    assign err_cnt = cnt_q;

endmodule

// File: tb/tb_add8_err_monitor.sv
// Four monitors swept in parallel against different adder models: randomized
// approximate, exact XOR 1, tied-to-zero, and an exact adder registered twice.
module tb_add8_err_monitor;

    logic        clk;
    logic        rstN   [4];
    logic        startS [4];
    logic [7:0]  sa     [4];
    logic [7:0]  sb     [4];
    logic [8:0]  dutO   [4];
    logic        busyS  [4];
    logic        doneS  [4];
    logic [24:0] eSum   [4];
    logic [34:0] eSq    [4];
    logic [8:0]  eMax   [4];
    logic [16:0] eCnt   [4];

    int         checkCnt = 0;
    int         passCnt  = 0;
    int         l0;
    logic [7:0] key0;
    logic [8:0] p1, p2;

    typedef struct {
        string  name;
        int     inst;
        int     checkAt;
        longint expSum;
        longint expSq;
        longint expMax;
        longint expCnt;
    } result_t;

    result_t tbl [4];

    // Lower bits OR-ed, upper bits added, with an occasional overshoot chosen by a random key.
    function automatic logic [8:0] approxAdd(input logic [7:0] a, input logic [7:0] b,
                                             input int l, input logic [7:0] key);
        int lowMask, hi;
        lowMask = (1 << l) - 1;
        hi = ((int'(a) >> l) + (int'(b) >> l)) << l;
        if (((a ^ b) & key) == 8'd0) hi = hi + (1 << l);
        return 9'(hi | (int'(a | b) & lowMask));
    endfunction

    add8_err_monitor #(.LAT(0)) u0 (
        .clk(clk), .rst_n(rstN[0]), .start(startS[0]), .stim_a(sa[0]), .stim_b(sb[0]),
        .dut_o(dutO[0]), .busy(busyS[0]), .done(doneS[0]), .err_sum(eSum[0]),
        .err_sq(eSq[0]), .err_max(eMax[0]), .err_cnt(eCnt[0]));
    add8_err_monitor #(.LAT(0)) u1 (
        .clk(clk), .rst_n(rstN[1]), .start(startS[1]), .stim_a(sa[1]), .stim_b(sb[1]),
        .dut_o(dutO[1]), .busy(busyS[1]), .done(doneS[1]), .err_sum(eSum[1]),
        .err_sq(eSq[1]), .err_max(eMax[1]), .err_cnt(eCnt[1]));
    add8_err_monitor #(.LAT(0)) u2 (
        .clk(clk), .rst_n(rstN[2]), .start(startS[2]), .stim_a(sa[2]), .stim_b(sb[2]),
        .dut_o(dutO[2]), .busy(busyS[2]), .done(doneS[2]), .err_sum(eSum[2]),
        .err_sq(eSq[2]), .err_max(eMax[2]), .err_cnt(eCnt[2]));
    add8_err_monitor #(.LAT(2)) u3 (
        .clk(clk), .rst_n(rstN[3]), .start(startS[3]), .stim_a(sa[3]), .stim_b(sb[3]),
        .dut_o(dutO[3]), .busy(busyS[3]), .done(doneS[3]), .err_sum(eSum[3]),
        .err_sq(eSq[3]), .err_max(eMax[3]), .err_cnt(eCnt[3]));

    assign dutO[0] = approxAdd(sa[0], sb[0], l0, key0);
    assign dutO[1] = ({1'b0, sa[1]} + {1'b0, sb[1]}) ^ 9'd1;
    assign dutO[2] = 9'd0;
    assign dutO[3] = p2;

    always @(posedge clk) begin
        p1 <= {1'b0, sa[3]} + {1'b0, sb[3]};
        p2 <= p1;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input longint act, input longint exp);
        checkCnt++;
        if (act == exp) passCnt++;
        else $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic applyStimulus(input int inst, input logic st);
        startS[inst] = st;
    endtask

    task automatic checkCleared(input int inst, input string tag);
        checkOutput({tag, " busy"},   busyS[inst], 0);
        checkOutput({tag, " done"},   doneS[inst], 0);
        checkOutput({tag, " stim_a"}, sa[inst],    0);
        checkOutput({tag, " stim_b"}, sb[inst],    0);
        checkOutput({tag, " err_sum"}, eSum[inst], 0);
        checkOutput({tag, " err_sq"},  eSq[inst],  0);
        checkOutput({tag, " err_max"}, eMax[inst], 0);
        checkOutput({tag, " err_cnt"}, eCnt[inst], 0);
    endtask

    task automatic checkResult(input result_t r);
        checkOutput({r.name, " done"},    doneS[r.inst], 1);
        checkOutput({r.name, " err_sum"}, eSum[r.inst],  r.expSum);
        checkOutput({r.name, " err_sq"},  eSq[r.inst],   r.expSq);
        checkOutput({r.name, " err_max"}, eMax[r.inst],  r.expMax);
        checkOutput({r.name, " err_cnt"}, eCnt[r.inst],  r.expCnt);
    endtask

    initial begin
        longint s0 = 0, q0 = 0, m0 = 0, c0 = 0, q2 = 0;

        l0   = $urandom_range(1, 4);
        key0 = 8'($urandom);
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                int e;
                e = int'(approxAdd(8'(a), 8'(b), l0, key0)) - (a + b);
                if (e < 0) e = -e;
                s0 += e;
                q0 += e * e;
                if (e > m0) m0 = e;
                if (e != 0) c0++;
                q2 += (a + b) * (a + b);
            end
        end
        $display("[TB] approx model: low bits %0d, key %0h", l0, key0);

        tbl[0] = '{"approx",   0, 65540, s0,        q0, m0,  c0};
        tbl[1] = '{"xor1",     1, 65540, 65536,  65536, 1,   65536};
        tbl[2] = '{"zero",     2, 65537, 16711680,  q2, 510, 65535};
        tbl[3] = '{"lat2",     3, 65843, 0,          0, 0,   0};

        for (int i = 0; i < 4; i++) begin
            rstN[i] = 1'b0;
            applyStimulus(i, 1'b0);
        end
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) checkCleared(i, $sformatf("reset u%0d", i));
        for (int i = 0; i < 4; i++) rstN[i] = 1'b1;
        @(negedge clk);
        checkCleared(0, "idle u0");
        for (int i = 0; i < 4; i++) applyStimulus(i, 1'b1);

        for (int j = 1; j <= 65845; j++) begin
            @(negedge clk);
            if (j == 1) begin
                for (int i = 0; i < 4; i++) applyStimulus(i, 1'b0);
                checkOutput("u0 busy at k=0", busyS[0], 1);
                checkOutput("u0 stim_a at k=0", sa[0], 0);
            end
            if (j == 301) begin
                rstN[3] = 1'b0;
                #1;
                checkOutput("u3 async reset stim_a", sa[3], 0);
                checkOutput("u3 async reset stim_b", sb[3], 0);
                checkOutput("u3 async reset busy", busyS[3], 0);
            end
            if (j == 302) rstN[3] = 1'b1;
            if (j == 303) applyStimulus(3, 1'b1);
            if (j == 304) applyStimulus(3, 1'b0);
            if (j == 1001) begin
                checkOutput("u1 stim_a at k=1000", sa[1], 232);
                checkOutput("u1 stim_b at k=1000", sb[1], 3);
                applyStimulus(1, 1'b1);
            end
            if (j == 1002) begin
                applyStimulus(1, 1'b0);
                checkOutput("u1 stim_a after ignored start", sa[1], 233);
                checkOutput("u1 busy after ignored start", busyS[1], 1);
            end
            if (j == 65536) begin
                checkOutput("u0 busy at k=65535", busyS[0], 1);
                checkOutput("u0 stim_a at k=65535", sa[0], 255);
                checkOutput("u0 stim_b at k=65535", sb[0], 255);
            end
            if (j == 65537) begin
                checkOutput("u0 done after sweep", doneS[0], 1);
                checkOutput("u0 busy after sweep", busyS[0], 0);
                checkOutput("u0 stim_a in DONE", sa[0], 0);
                checkOutput("u3 busy mid sweep", busyS[3], 1);
            end
            if (j == 65545) applyStimulus(2, 1'b1);
            if (j == 65546) begin
                applyStimulus(2, 1'b0);
                checkOutput("u2 restart busy", busyS[2], 1);
                checkOutput("u2 restart done", doneS[2], 0);
                checkOutput("u2 restart err_sum", eSum[2], 0);
                checkOutput("u2 restart err_max", eMax[2], 0);
                checkOutput("u2 restart err_cnt", eCnt[2], 0);
            end
            if (j == 65839) checkOutput("u3 stim_a at k=65535", sa[3], 255);
            if (j == 65840 || j == 65841) begin
                checkOutput($sformatf("u3 drain busy @%0d", j), busyS[3], 1);
                checkOutput($sformatf("u3 drain done @%0d", j), doneS[3], 0);
                checkOutput($sformatf("u3 drain stim_a @%0d", j), sa[3], 0);
                checkOutput($sformatf("u3 drain stim_b @%0d", j), sb[3], 0);
            end
            if (j == 65842) begin
                checkOutput("u3 done latency", doneS[3], 1);
                checkOutput("u3 busy in DONE", busyS[3], 0);
            end
            for (int e = 0; e < 4; e++) begin
                if (j == tbl[e].checkAt) checkResult(tbl[e]);
            end
        end

        $display("%0d/%0d checks passed", passCnt, checkCnt);
        $finish;
    end

endmodule

// File: doc/add8_err_monitor.md
ADD8_ERR_MONITOR -- requirements
Module: add8_err_monitor

Interface
REQ-001 Parameter LAT, default 0: pipeline latency of the adder under test, in cycles; legal range 0..3.
REQ-002 clk  input  1  sole clock, rising-edge active.
REQ-003 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 start  input  1  single-cycle request to begin an exhaustive sweep.
REQ-005 stim_a  output  8  operand A driven to the adder under test.
REQ-006 stim_b  output  8  operand B driven to the adder under test.
REQ-007 dut_o  input  9  approximate sum returned by the adder under test.
REQ-008 busy  output  1  high while a sweep or drain is in progress.
REQ-009 done  output  1  high while results of a completed sweep are held.
REQ-010 err_sum  output  25  sum of |dut_o - (A+B)| over all samples.
REQ-011 err_sq  output  35  sum of squared errors.
REQ-012 err_max  output  9  worst-case absolute error.
REQ-013 err_cnt  output  17  number of samples with nonzero error.

Function
REQ-014 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-015 IDLE or DONE with start=1 SHALL clear all accumulators and the 16-bit sample index k, and enter RUN on the next edge.
REQ-016 In RUN, stim_a SHALL equal k[7:0] and stim_b SHALL equal k[15:8].
REQ-017 k SHALL increment once per RUN cycle.
REQ-018 RUN SHALL last exactly 65536 cycles, with k from 0 to 65535.
REQ-019 On the edge where k=65535, the FSM SHALL enter DRAIN if LAT>0, otherwise DONE.
REQ-020 DRAIN SHALL last exactly LAT cycles, then enter DONE.
REQ-021 The exact 9-bit sum A+B SHALL be delayed through a LAT-stage register line so that it aligns with the dut_o sample for the same operands.
REQ-022 A sample SHALL be valid LAT cycles after its operands are issued.
REQ-023 Exactly 65536 samples SHALL be accumulated per sweep; no sample SHALL be lost and none counted twice.
REQ-024 err SHALL equal the 9-bit absolute difference |dut_o - exact| (range 0..511), computed without wrap.
REQ-025 Each valid sample SHALL update accumulators at the clock edge: err_sum += err; err_sq += err*err; err_max = max(err_max, err); err_cnt += (err != 0).
REQ-026 Accumulators SHALL not saturate or wrap; the widths cover the worst case.
REQ-027 busy SHALL be 1 in RUN and DRAIN only.
REQ-028 done SHALL be 1 in DONE only.
REQ-029 Results SHALL stay stable in DONE until the next accepted start.
REQ-030 start in RUN or DRAIN SHALL be ignored, with no restart and no accumulator effect.
REQ-031 In IDLE, DONE and DRAIN, stim_a and stim_b SHALL be driven 0.
REQ-032 dut_o SHALL be ignored in IDLE and DONE.

Reset
REQ-033 rst_n low SHALL immediately force the following, regardless of state: IDLE; k=0; delay line cleared; stim_a=0; stim_b=0; busy=0; done=0; err_sum=0; err_sq=0; err_max=0; err_cnt=0.
REQ-034 Reset mid-sweep SHALL discard partial results.
REQ-035 After rst_n deasserts, the block SHALL wait in IDLE for start.

Verification
REQ-036 LAT=0, exact combinational adder, start pulse -> busy for 65536 cycles, then done=1 with err_sum=0, err_sq=0, err_max=0, err_cnt=0.
REQ-037 LAT=0, dut_o = exact XOR 1 -> err_sum=65536, err_sq=65536, err_max=1, err_cnt=65536.
REQ-038 LAT=0, dut_o tied to 0 -> err_sum=16711680, err_max=510, err_cnt=65535.
REQ-039 LAT=2, exact adder registered twice -> all metrics 0; done rises 65538 cycles after RUN entry; stim is 0 during the 2 DRAIN cycles.
REQ-040 start pulsed again at k=1000 -> ignored, sweep completes normally; then a start in DONE -> accumulators cleared and a new sweep begins.
REQ-041 rst_n pulsed low at k=30000 -> all outputs 0 asynchronously; a subsequent start yields results identical to a clean sweep.
